// File: rtl/ow_pkg.sv
// Shared definitions for the 1-wire / single-wire command sequencer:
// opcodes, FSM and step encodings, status bit positions, read-range helper.
package ow_pkg;

    localparam logic [3:0] OP_RESET  = 4'd0;
    localparam logic [3:0] OP_WRITE  = 4'd1;
    localparam logic [3:0] OP_READ   = 4'd2;
    localparam logic [3:0] OP_STATUS = 4'd3;
    localparam logic [3:0] OP_SWREAD = 4'd4;
    localparam logic [3:0] OP_TRANS  = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        STEP_RESET,
        STEP_WRITE,
        STEP_READ,
        STEP_SW
    } step_e;

    localparam int unsigned STAT_OK      = 0;
    localparam int unsigned STAT_PRES    = 1;
    localparam int unsigned STAT_NOPRES  = 2;
    localparam int unsigned STAT_TIMEOUT = 3;
    localparam int unsigned STAT_BADCMD  = 4;
    localparam int unsigned STAT_OVERRUN = 5;

    // Reading n bytes fills the top of the 64-bit engine buffer: bits 64-8n..63.
    function automatic logic [5:0] rd_start_bit(input logic [3:0] n);
        logic [6:0] s;
        if (n == 4'd0) begin
            return 6'd63;
        end
        s = 7'd64 - {n, 3'b000};
        return s[5:0];
    endfunction

endpackage

// File: rtl/ow_sequencer_if.sv
// Command, engine and response signals of the sequencer, bundled as one interface.
interface ow_sequencer_if;

    logic        cmd_valid;
    logic [63:0] cmd_word;
    logic        cmd_ready;
    logic        ow_reset;
    logic        ow_write;
    logic        ow_read;
    logic        sw_read;
    logic [7:0]  ow_wr_byte;
    logic [5:0]  ow_start_bit;
    logic [5:0]  ow_end_bit;
    logic        eng_busy;
    logic        ow_presence;
    logic [63:0] eng_rd_data;
    logic [63:0] rsp_data;
    logic [7:0]  rsp_status;
    logic        rsp_valid;
    logic        dev_present;

    modport master (
        input  cmd_valid, cmd_word, eng_busy, ow_presence, eng_rd_data,
        output cmd_ready, ow_reset, ow_write, ow_read, sw_read,
               ow_wr_byte, ow_start_bit, ow_end_bit,
               rsp_data, rsp_status, rsp_valid, dev_present
    );

    modport slave (
        output cmd_valid, cmd_word, eng_busy, ow_presence, eng_rd_data,
        input  cmd_ready, ow_reset, ow_write, ow_read, sw_read,
               ow_wr_byte, ow_start_bit, ow_end_bit,
               rsp_data, rsp_status, rsp_valid, dev_present
    );

endinterface

// File: rtl/ow_busy_watchdog.sv
// Saturating 24-bit cycle counter; restarts on load and flags once limit cycles have passed.
module ow_busy_watchdog (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] limit,
    output logic        expired
);

    logic [23:0] cnt_q, cnt_d;

    always_comb begin
        if (load) begin
            cnt_d = '0;
        end else if (cnt_q == 24'hFF_FFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= limit);

endmodule

// File: rtl/ow_sequencer.sv
// Decodes one 64-bit SPI command word into 1-wire / single-wire engine steps,
// sequences them against the shared busy line and returns data plus a status byte.
module ow_sequencer
    import ow_pkg::*;
#(
    parameter logic [23:0] START_TO = 24'd16,
    parameter logic [23:0] BUSY_TO  = 24'd12000000,
    parameter logic [3:0]  MAX_WR   = 4'd6
) (
    input  logic           clk,
    input  logic           rst,
    ow_sequencer_if.master bus
);

    state_e      state_q, state_d;
    step_e       step_q, step_d;
    logic [63:0] cmd_q, cmd_d;
    logic [2:0]  wr_idx_q, wr_idx_d;
    logic        busy_seen_q, busy_seen_d;
    logic        pres_q, pres_d;
    logic        nopres_q, nopres_d;
    logic        to_q, to_d;
    logic        bad_q, bad_d;
    logic        ovr_q, ovr_d;
    logic        dev_present_q, dev_present_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [7:0]  rsp_status_q, rsp_status_d;
    logic [7:0]  wr_byte_q, wr_byte_d;
    logic [5:0]  start_q, start_d;
    logic [5:0]  end_q, end_d;
    logic [63:0] wr_shift;
    logic [3:0]  cmd_op, cmd_rd_len, cmd_wr_len;
    logic        wd_load, wd_expired;
    logic [23:0] wd_limit;

    assign cmd_op     = cmd_q[7:4];
    assign cmd_rd_len = cmd_q[3:0];
    assign cmd_wr_len = cmd_q[11:8];

    function automatic logic cmd_is_bad(input logic [63:0] w);
        logic [3:0] op, rd, wr;
        op = w[7:4];
        rd = w[3:0];
        wr = w[11:8];
        return (op > OP_TRANS) || (rd > 4'd8) || (wr > MAX_WR) ||
               (op == OP_TRANS && wr == 4'd0 && rd == 4'd0);
    endfunction

    // One counter serves both wait states; it restarts on every state change.
    assign wd_load  = (state_d != state_q);
    assign wd_limit = (state_q == ST_WAIT_HI) ? START_TO : BUSY_TO;

    ow_busy_watchdog u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load),
        .limit   (wd_limit),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= STEP_RESET;
            cmd_q         <= '0;
            wr_idx_q      <= '0;
            busy_seen_q   <= 1'b0;
            pres_q        <= 1'b0;
            nopres_q      <= 1'b0;
            to_q          <= 1'b0;
            bad_q         <= 1'b0;
            ovr_q         <= 1'b0;
            dev_present_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            wr_byte_q     <= '0;
            start_q       <= '0;
            end_q         <= '0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            cmd_q         <= cmd_d;
            wr_idx_q      <= wr_idx_d;
            busy_seen_q   <= busy_seen_d;
            pres_q        <= pres_d;
            nopres_q      <= nopres_d;
            to_q          <= to_d;
            bad_q         <= bad_d;
            ovr_q         <= ovr_d;
            dev_present_q <= dev_present_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            wr_byte_q     <= wr_byte_d;
            start_q       <= start_d;
            end_q         <= end_d;
        end
    end

    always_comb begin
        // NOTE: everything gets a default first so no path through this block can infer a latch.
        state_d       = state_q;
        step_d        = step_q;
        cmd_d         = cmd_q;
        wr_idx_d      = wr_idx_q;
        busy_seen_d   = busy_seen_q;
        pres_d        = pres_q;
        nopres_d      = nopres_q;
        to_d          = to_q;
        bad_d         = bad_q;
        ovr_d         = ovr_q;
        dev_present_d = dev_present_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        wr_byte_d     = wr_byte_q;
        start_d       = start_q;
        end_d         = end_q;
        wr_shift      = '0;

        if (bus.cmd_valid && state_q != ST_IDLE) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d    = bus.cmd_word;
                    bad_d    = cmd_is_bad(bus.cmd_word);
                    pres_d   = 1'b0;
                    nopres_d = 1'b0;
                    to_d     = 1'b0;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d  = ST_ISSUE;
                wr_idx_d = '0;
                if (bad_q) begin
                    state_d = ST_DONE;
                end else begin
                    unique case (cmd_op)
                        OP_WRITE:  step_d = STEP_WRITE;
                        OP_READ:   step_d = STEP_READ;
                        OP_SWREAD: step_d = STEP_SW;
                        OP_STATUS: begin
                            pres_d  = dev_present_q;
                            state_d = ST_DONE;
                        end
                        default:   step_d = STEP_RESET;
                    endcase
                end
            end
            ST_ISSUE: begin
                busy_seen_d = bus.eng_busy;
                state_d     = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (bus.eng_busy || busy_seen_q) begin
                    state_d = ST_WAIT_LO;
                end else if (wd_expired) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.eng_busy) begin
                    state_d = ST_NEXT;
                end else if (wd_expired) begin
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_NEXT: begin
                state_d = ST_DONE;
                unique case (step_q)
                    STEP_RESET: begin
                        dev_present_d = bus.ow_presence;
                        pres_d        = bus.ow_presence;
                        if (cmd_op == OP_TRANS) begin
                            if (!bus.ow_presence) begin
                                nopres_d = 1'b1;
                            end else if (cmd_wr_len != 4'd0) begin
                                step_d   = STEP_WRITE;
                                wr_idx_d = '0;
                                state_d  = ST_ISSUE;
                            end else begin
                                step_d  = STEP_READ;
                                state_d = ST_ISSUE;
                            end
                        end
                    end
                    STEP_WRITE: begin
                        if (cmd_op == OP_TRANS && ({1'b0, wr_idx_q} + 4'd1) < cmd_wr_len) begin
                            wr_idx_d = wr_idx_q + 3'd1;
                            state_d  = ST_ISSUE;
                        end else if (cmd_op == OP_TRANS && cmd_rd_len != 4'd0) begin
                            step_d  = STEP_READ;
                            state_d = ST_ISSUE;
                        end
                    end
                    default: rsp_data_d = bus.eng_rd_data;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        // Range and byte registers are loaded on entry to ISSUE and held until the next issue.
        if (state_d == ST_ISSUE) begin
            if (step_d == STEP_WRITE) begin
                wr_shift  = cmd_q >> {wr_idx_d, 3'b000};
                wr_byte_d = wr_shift[23:16];
                start_d   = 6'd0;
                end_d     = 6'd7;
            end else if (step_d == STEP_READ) begin
                start_d = rd_start_bit(cmd_rd_len);
                end_d   = 6'd63;
            end
        end

        // Status is composed on entry to DONE so it is already valid while rsp_valid is high.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            rsp_status_d               = '0;
            rsp_status_d[STAT_PRES]    = pres_d;
            rsp_status_d[STAT_NOPRES]  = nopres_d;
            rsp_status_d[STAT_TIMEOUT] = to_d;
            rsp_status_d[STAT_BADCMD]  = bad_d;
            rsp_status_d[STAT_OVERRUN] = ovr_d;
            rsp_status_d[STAT_OK]      = !(nopres_d || to_d || bad_d || ovr_d);
            ovr_d                      = 1'b0;
        end
    end

    always_comb begin
        bus.cmd_ready    = (state_q == ST_IDLE);
        bus.ow_reset     = (state_q == ST_ISSUE) && (step_q == STEP_RESET);
        bus.ow_write     = (state_q == ST_ISSUE) && (step_q == STEP_WRITE);
        bus.ow_read      = (state_q == ST_ISSUE) && (step_q == STEP_READ);
        bus.sw_read      = (state_q == ST_ISSUE) && (step_q == STEP_SW);
        bus.rsp_valid    = (state_q == ST_DONE);
        bus.ow_wr_byte   = wr_byte_q;
        bus.ow_start_bit = start_q;
        bus.ow_end_bit   = end_q;
        bus.rsp_data     = rsp_data_q;
        bus.rsp_status   = rsp_status_q;
        bus.dev_present  = dev_present_q;
    end

endmodule

// File: tb/tb_ow_sequencer.sv
// Directed bench for ow_sequencer: a small engine responder logs strobes and plays busy,
// while one initial block walks through the command set with hand-computed expectations.
module tb_ow_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ow_sequencer_if bus ();

    ow_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Engine responder state; written only by the responder except the control knobs.
    logic [15:0] slog[$];
    int  eng_delay  = 1;
    int  eng_len    = 40;
    bit  eng_enable = 1'b1;
    bit  eng_kill   = 1'b0;
    int  wait_cnt   = 0;
    int  hi_cnt     = 0;

    initial begin
        bus.eng_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ow_reset) slog.push_back({8'h52, 8'h00});
            if (bus.ow_write) slog.push_back({8'h57, bus.ow_wr_byte});
            if (bus.ow_read)  slog.push_back({8'h44, 8'h00});
            if (bus.sw_read)  slog.push_back({8'h53, 8'h00});
            if ((bus.ow_reset || bus.ow_write || bus.ow_read || bus.sw_read) && eng_enable) begin
                wait_cnt = eng_delay;
                hi_cnt   = eng_len;
            end
            if (eng_kill) begin
                wait_cnt = 0;
                hi_cnt   = 0;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                bus.eng_busy = 1'b0;
            end else if (hi_cnt > 0) begin
                hi_cnt--;
                bus.eng_busy = 1'b1;
            end else begin
                bus.eng_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not terminate");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [63:0] w);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            step();
            n++;
        end
        check("cmd_ready_before_send", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_word  = w;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget, output int cycles);
        int n = 0;
        while (!bus.rsp_valid && n < budget) begin
            step();
            n++;
        end
        cycles = n;
        check({tag, "_rsp_seen"}, 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic bad_cmd(input string tag, input logic [63:0] w);
        int n0;
        n0 = slog.size();
        send_cmd(w);
        check({tag, "_no_rsp_in_decode"}, 64'(bus.rsp_valid), 64'd0);
        step();
        check({tag, "_rsp_2_cycles"}, 64'(bus.rsp_valid), 64'd1);
        check({tag, "_status"}, 64'(bus.rsp_status), 64'h10);
        check({tag, "_no_strobe"}, 64'(slog.size() - n0), 64'd0);
    endtask

    initial begin
        int n0;
        int cyc;
        int seen;

        bus.cmd_valid   = 1'b0;
        bus.cmd_word    = '0;
        bus.ow_presence = 1'b0;
        bus.eng_rd_data = '0;
        repeat (3) step();
        check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("reset_status", 64'(bus.rsp_status), 64'd0);
        check("reset_dev_present", 64'(bus.dev_present), 64'd0);
        check("reset_rsp_data", bus.rsp_data, 64'd0);
        rst = 1'b0;
        step();

        // Op 0: reset with presence, busy for 40 cycles.
        bus.ow_presence = 1'b1;
        n0 = slog.size();
        send_cmd(64'h0000_0000_0000_0000);
        wait_rsp("op0", 200, cyc);
        check("op0_status", 64'(bus.rsp_status), 64'h03);
        check("op0_dev_present", 64'(bus.dev_present), 64'd1);
        check("op0_strobe_count", 64'(slog.size() - n0), 64'd1);
        check("op0_strobe_kind", 64'(slog[n0]), 64'h5200);

        // Op 2, rd_len 2: upper two bytes of the engine buffer.
        eng_len = 10;
        bus.eng_rd_data = 64'hA5A5_0000_0000_1234;
        n0 = slog.size();
        send_cmd(64'h0000_0000_0000_0022);
        wait_rsp("op2_rd2", 200, cyc);
        check("op2_rd2_start", 64'(bus.ow_start_bit), 64'd48);
        check("op2_rd2_end", 64'(bus.ow_end_bit), 64'd63);
        check("op2_rd2_data", bus.rsp_data, 64'hA5A5_0000_0000_1234);
        check("op2_rd2_status", 64'(bus.rsp_status), 64'h01);
        check("op2_rd2_strobe", 64'(slog[n0]), 64'h4400);

        // Op 2, rd_len 8: full buffer, start bit 0.
        bus.eng_rd_data = 64'hDEAD_BEEF_0123_4567;
        send_cmd(64'h0000_0000_0000_0028);
        wait_rsp("op2_rd8", 200, cyc);
        check("op2_rd8_start", 64'(bus.ow_start_bit), 64'd0);
        check("op2_rd8_data", bus.rsp_data, 64'hDEAD_BEEF_0123_4567);

        // Op 5: reset, write CC, write 44, no read.
        n0 = slog.size();
        send_cmd(64'h0000_0000_44CC_0250);
        wait_rsp("op5_wr2", 300, cyc);
        check("op5_wr2_count", 64'(slog.size() - n0), 64'd3);
        check("op5_wr2_first", 64'(slog[n0]), 64'h5200);
        check("op5_wr2_second", 64'(slog[n0 + 1]), 64'h57CC);
        check("op5_wr2_third", 64'(slog[n0 + 2]), 64'h5744);
        check("op5_wr2_status", 64'(bus.rsp_status), 64'h03);
        check("op5_wr2_range", {52'd0, bus.ow_start_bit, bus.ow_end_bit}, 64'h007);

        // Op 5 with no presence: aborts after the reset step.
        bus.ow_presence = 1'b0;
        n0 = slog.size();
        send_cmd(64'h0000_0000_44CC_0250);
        wait_rsp("op5_nopres", 300, cyc);
        check("op5_nopres_count", 64'(slog.size() - n0), 64'd1);
        check("op5_nopres_status", 64'(bus.rsp_status), 64'h04);
        check("op5_nopres_dev_present", 64'(bus.dev_present), 64'd0);

        // Op 4 single-wire read captures the buffer.
        bus.eng_rd_data = 64'h1122_3344_5566_7788;
        n0 = slog.size();
        send_cmd(64'h0000_0000_0000_0040);
        wait_rsp("op4", 200, cyc);
        check("op4_strobe", 64'(slog[n0]), 64'h5300);
        check("op4_data", bus.rsp_data, 64'h1122_3344_5566_7788);

        // Op 3: no engine access, data unchanged, presence from last reset slot (0).
        n0 = slog.size();
        bus.eng_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        send_cmd(64'h0000_0000_0000_0030);
        wait_rsp("op3", 20, cyc);
        check("op3_status", 64'(bus.rsp_status), 64'h01);
        check("op3_data", bus.rsp_data, 64'h1122_3344_5566_7788);
        check("op3_no_strobe", 64'(slog.size() - n0), 64'd0);

        // Rejected commands.
        bad_cmd("bad_op9", 64'h0000_0000_0000_0090);
        bad_cmd("bad_rd9", 64'h0000_0000_0000_0029);
        bad_cmd("bad_wr7", 64'h0000_0000_0000_0751);
        bad_cmd("bad_op5_empty", 64'h0000_0000_0000_0050);

        // Busy never rises: start timeout.
        eng_enable = 1'b0;
        send_cmd(64'h0000_0000_0000_0000);
        wait_rsp("tmo", 100, cyc);
        check("tmo_status", 64'(bus.rsp_status), 64'h08);
        check("tmo_window", 64'(cyc >= 16 && cyc <= 22), 64'd1);

        // Timeout plus a command arriving mid-wait: overrun reported, then cleared.
        send_cmd(64'h0000_0000_0000_0000);
        repeat (5) step();
        bus.cmd_word  = 64'h0000_0000_0000_0030;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        wait_rsp("ovr", 100, cyc);
        check("ovr_status", 64'(bus.rsp_status), 64'h28);
        send_cmd(64'h0000_0000_0000_0030);
        wait_rsp("ovr_clear", 20, cyc);
        check("ovr_clear_status", 64'(bus.rsp_status), 64'h01);

        // Busy high only in the strobe cycle must still count as seen.
        eng_enable      = 1'b1;
        eng_delay       = 0;
        eng_len         = 1;
        bus.ow_presence = 1'b1;
        send_cmd(64'h0000_0000_0000_0000);
        wait_rsp("short_busy", 60, cyc);
        check("short_busy_status", 64'(bus.rsp_status), 64'h03);
        check("short_busy_dev_present", 64'(bus.dev_present), 64'd1);

        // Reset during WAIT_LO of an op 2 read: everything clears, no response.
        eng_delay = 1;
        eng_len   = 40;
        send_cmd(64'h0000_0000_0000_0021);
        repeat (10) step();
        check("midrst_busy_active", 64'(bus.eng_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_status", 64'(bus.rsp_status), 64'd0);
        check("midrst_data", bus.rsp_data, 64'd0);
        check("midrst_dev_present", 64'(bus.dev_present), 64'd0);
        check("midrst_range", {52'd0, bus.ow_start_bit, bus.ow_end_bit}, 64'd0);
        check("midrst_wr_byte", 64'(bus.ow_wr_byte), 64'd0);
        check("midrst_strobes",
              64'({bus.ow_reset, bus.ow_write, bus.ow_read, bus.sw_read, bus.rsp_valid}), 64'd0);
        eng_kill = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
            step();
            if (bus.rsp_valid) seen++;
        end
        eng_kill = 1'b0;
        check("midrst_no_rsp", 64'(seen), 64'd0);
        check("midrst_idle", 64'(bus.cmd_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ow_sequencer.md
Name: ow_sequencer

Overview:
- Command sequencer between the SPI slave receive buffer and the shared 1-wire / single-wire engines.
- Accepts one 64-bit command word per SPI frame and decodes it into engine strobes.
- Multi-step commands (reset, then writes, then read) are sequenced against the shared engine busy line.
- Returns a 64-bit response word plus a status byte for the SPI transmit buffer.

Parameters:
- START_TO, 16, max cycles from strobe to busy rising before a timeout.
- BUSY_TO, 24'd12000000, max cycles busy may stay high before a timeout.
- MAX_WR, 6, max write bytes per command.

Ports:
- clk  in  1  system clock (PLL c0)
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  one-cycle pulse: SPI frame received
- cmd_word  in  64  [7:4] opcode, [3:0] rd_len, [11:8] wr_len, [63:16] write bytes (first byte at [23:16])
- cmd_ready  out  1  high only in IDLE
- ow_reset  out  1  one-cycle strobe, 1-wire reset/presence
- ow_write  out  1  one-cycle strobe, write ow_wr_byte
- ow_read  out  1  one-cycle strobe, read bits ow_start_bit..ow_end_bit
- sw_read  out  1  one-cycle strobe, single-wire read
- ow_wr_byte  out  8  byte for current write
- ow_start_bit  out  6  first read bit index
- ow_end_bit  out  6  last read bit index
- eng_busy  in  1  shared engine busy
- ow_presence  in  1  presence seen during reset slot
- eng_rd_data  in  64  engine read buffer
- rsp_data  out  64  captured read data
- rsp_status  out  8  [0] ok, [1] presence, [2] no-presence abort, [3] timeout, [4] bad cmd, [5] overrun, [7:6] 0
- rsp_valid  out  1  one-cycle pulse: response updated
- dev_present  out  1  presence from last reset slot

Behaviour:
- Reset (async): FSM to IDLE.
  - All strobes, rsp_valid, rsp_status, dev_present go to 0.
  - rsp_data, ow_wr_byte, ow_start_bit and ow_end_bit go to 0.
  - Reset mid-operation aborts silently with no rsp_valid.
- Opcodes:
  - 0 = reset
  - 1 = write one byte, [23:16]
  - 2 = read rd_len bytes
  - 3 = status only, no engine access
  - 4 = single-wire read
  - 5 = transaction: reset, then wr_len writes, then read if rd_len > 0
  - Opcodes 6-15 are rejected.
- Validation, performed in IDLE on cmd_valid:
  - Failing conditions: illegal opcode; rd_len > 8; wr_len > MAX_WR; op 5 with wr_len = 0 and rd_len = 0.
  - On failure: no strobe. rsp_status = bad cmd, and rsp_valid pulses 2 cycles after cmd_valid.
- Read range for rd_len = n:
  - n = 0: start = end = 63.
  - n > 0: start = 64 - 8n, end = 63.
  - Write range: start = 0, end = 7.
  - Range outputs are stable from the strobe cycle until the step completes.
- FSM states: IDLE, DECODE, ISSUE, WAIT_HI, WAIT_LO, NEXT, DONE.
  - IDLE --cmd_valid--> DECODE. The command is latched in the same cycle.
  - DECODE --> ISSUE, or DONE on bad cmd.
  - ISSUE asserts exactly one strobe for 1 cycle, then goes to WAIT_HI.
  - WAIT_HI --eng_busy=1--> WAIT_LO. If START_TO cycles elapse first: timeout, go to DONE.
  - WAIT_LO --eng_busy=0--> NEXT. If BUSY_TO cycles elapse first: timeout, go to DONE.
  - NEXT samples results:
    - After a reset step: dev_present <= ow_presence. If 0 in op 5, abort with no-presence.
    - After a read step: rsp_data <= eng_rd_data.
    - NEXT then selects the next step (ISSUE) or DONE.
  - DONE pulses rsp_valid for 1 cycle, updates rsp_status (ok = no error bits set), then returns to IDLE.
- Step order in op 5: reset, write byte k = cmd_word[23+8k:16+8k] for k = 0..wr_len-1, then read.
- Op 3 goes DECODE to DONE. rsp_data is unchanged, and status reflects the last presence.
- cmd_valid while not IDLE:
  - The command is ignored.
  - The overrun bit is set sticky.
  - The bit is reported in the next DONE, then cleared.
- Same-cycle events:
  - Busy already high in the strobe cycle is treated as seen in WAIT_HI on the next cycle.
  - cmd_valid coinciding with the DONE cycle counts as overrun.
- Watchdog counters are 24 bits, reload on each state entry, and saturate with no wrap.

Decomposition:
- Package ow_pkg holds:
  - opcode localparams (OP_RESET .. OP_TRANS)
  - FSM state encoding
  - status bit indices
  - rd_len-to-start_bit helper function
- One sub-module: ow_busy_watchdog.
  - Inputs: clk, rst, load, limit.
  - Output: expired.
  - Shared by WAIT_HI and WAIT_LO.

Test Plan:
- Op 0, engine busy 40 cycles with presence = 1 -> one ow_reset pulse; rsp_status = 8'h03; dev_present = 1.
- Op 2 rd_len = 2, eng_rd_data = 64'hA5A5_0000_0000_1234 -> start 48, end 63; rsp_data equals eng_rd_data; status 8'h01.
- Op 5 wr_len = 2 (bytes CC, 44), rd_len = 0 with presence = 1 -> order reset, write CC, write 44; exactly 3 strobes; status 8'h03.
- Op 5 with presence = 0 -> only ow_reset issued, no writes; status 8'h04; dev_present = 0.
- Busy never rises -> timeout after START_TO cycles; status 8'h08. A second cmd_valid during the wait sets overrun; status 8'h28.
- Opcode 4'h9 -> status 8'h10, no strobes. rst asserted during WAIT_LO of op 2 -> all outputs 0 and no rsp_valid.
